// File: rtl/bus_if_pkg.sv
// Shared types for the burst bus interface: FSM states and the bus_state phase-code layout.
package bus_if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam int   BS_PREFIX_BIT  = 2;
   localparam int   BS_LAST_BIT    = 1;
   localparam int   BS_WRITE_BIT   = 0;
   localparam logic BS_ADDR_PREFIX = 1'b0;
   localparam logic BS_DATA_PREFIX = 1'b1;

   // Returns {found, index} of the lowest set mask bit at or above 'from'.
   function automatic logic [2:0] first_set(input logic [3:0] mask, input logic [2:0] from);
      logic [2:0] r;
      r = '0;
      for (int k = 3; k >= 0; k--) begin
         if (mask[k] && (3'(k) >= from)) r = {1'b1, 2'(k)};
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_addr_shadow.sv
// Tracks the address the peripheral currently holds and flags which address bytes must be resent.
module bus_addr_shadow
   import bus_if_pkg::*;
#(
   parameter int ADDR_BYTES = 2
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [8*ADDR_BYTES-1:0] cmp_addr,
   input  logic                    cmp_io,
   output logic [ADDR_BYTES-1:0]   send_mask,
   input  logic                    update,
   input  logic [8*ADDR_BYTES-1:0] upd_addr,
   input  logic [1:0]              upd_len,
   input  logic                    upd_io,
   input  logic                    invalidate
);

   localparam int AW = 8 * ADDR_BYTES;

   logic [AW-1:0] shadow_addr;
   logic          shadow_io;
   logic          shadow_valid;
   logic [AW-1:0] next_addr;

   // Peripheral auto-increments once per data byte, wrapping at the address width.
   assign next_addr = upd_addr + AW'(upd_len) + AW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          shadow_valid <= 1'b0;
      else if (invalidate) shadow_valid <= 1'b0;
      else if (update)     shadow_valid <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (update) begin
         shadow_addr <= next_addr;
         shadow_io   <= upd_io;
      end
   end

   always_comb begin
      send_mask = '0;
      for (int k = 0; k < ADDR_BYTES; k++) begin
         send_mask[k] = !shadow_valid || (shadow_io != cmp_io) ||
                        (cmp_addr[8*k +: 8] != shadow_addr[8*k +: 8]);
      end
   end

endmodule

// File: rtl/bus_if_burst.sv
// CPU memory port to 8-bit 4-phase req/ack bus bridge with multi-byte bursts and address elision.
module bus_if_burst
   import bus_if_pkg::*;
#(
   parameter int ADDR_BYTES = 2,
   parameter int DATA_BYTES = 4
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bus_handshake_ack,
   output logic                    bus_handshake_req,
   output logic [2:0]              bus_state,
   input  logic [7:0]              bus_data_in,
   output logic [7:0]              bus_data_out,
   output logic                    bus_output_enable,
   output logic                    bus_io,
   input  logic                    memory_read,
   input  logic                    memory_write,
   input  logic [8*ADDR_BYTES-1:0] memory_addr,
   input  logic                    memory_io,
   input  logic [1:0]              memory_len,
   input  logic [8*DATA_BYTES-1:0] memory_wdata,
   output logic [8*DATA_BYTES-1:0] memory_rdata,
   output logic                    memory_done,
   input  logic                    shadow_invalidate
);

   localparam int AW = 8 * ADDR_BYTES;
   localparam int DW = 8 * DATA_BYTES;

   state_t                state, nxt_state;
   logic [1:0]            idx, nxt_idx;
   logic [ADDR_BYTES-1:0] mask_q, cmp_mask, cur_mask;
   logic [AW-1:0]         addr_q, cur_addr;
   logic [DW-1:0]         wdata_q, cur_wdata;
   logic [1:0]            len_q, cur_len;
   logic                  write_q, io_q, cur_write;
   logic                  accept, phase_done, last_data, complete;
   logic [2:0]            hit;
   logic                  drv_oe;
   logic [7:0]            drv_data;
   logic [2:0]            drv_state;

   assign bus_io     = memory_io;
   assign accept     = (state == ST_IDLE) && (memory_read || memory_write) && !memory_done;
   assign phase_done = bus_handshake_req && bus_handshake_ack;
   assign last_data  = (state == ST_DATA) && (idx == len_q);
   assign complete   = phase_done && last_data;

   // In IDLE the first phase is set up straight from the request inputs.
   assign cur_addr  = (state == ST_IDLE) ? memory_addr  : addr_q;
   assign cur_wdata = (state == ST_IDLE) ? memory_wdata : wdata_q;
   assign cur_len   = (state == ST_IDLE) ? memory_len   : len_q;
   assign cur_write = (state == ST_IDLE) ? memory_write : write_q;
   assign cur_mask  = (state == ST_IDLE) ? cmp_mask     : mask_q;

   bus_addr_shadow #(.ADDR_BYTES(ADDR_BYTES)) u_shadow (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmp_addr   (memory_addr),
      .cmp_io     (memory_io),
      .send_mask  (cmp_mask),
      .update     (complete),
      .upd_addr   (addr_q),
      .upd_len    (len_q),
      .upd_io     (io_q),
      .invalidate (shadow_invalidate)
   );

   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      hit       = '0;
      if (accept) begin
         hit = first_set(4'(cur_mask), 3'd0);
         if (hit[2]) begin
            nxt_state = ST_ADDR;
            nxt_idx   = hit[1:0];
         end else begin
            nxt_state = ST_DATA;
            nxt_idx   = 2'd0;
         end
      end else if (phase_done) begin
         case (state)
            ST_ADDR: begin
               hit = first_set(4'(mask_q), {1'b0, idx} + 3'd1);
               if (hit[2]) begin
                  nxt_idx = hit[1:0];
               end else begin
                  nxt_state = ST_DATA;
                  nxt_idx   = 2'd0;
               end
            end
            ST_DATA: begin
               if (idx == len_q) begin
                  nxt_state = ST_IDLE;
                  nxt_idx   = 2'd0;
               end else begin
                  nxt_idx = idx + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Bus drive values follow the next phase so they are already stable when req rises.
   always_comb begin
      drv_oe    = 1'b0;
      drv_data  = '0;
      drv_state = '0;
      case (nxt_state)
         ST_ADDR: begin
            drv_oe                   = 1'b1;
            drv_state[BS_PREFIX_BIT] = BS_ADDR_PREFIX;
            drv_state[1:0]           = nxt_idx;
            for (int k = 0; k < ADDR_BYTES; k++) begin
               if (nxt_idx == 2'(k)) drv_data = cur_addr[8*k +: 8];
            end
         end
         ST_DATA: begin
            drv_oe                   = cur_write;
            drv_state[BS_PREFIX_BIT] = BS_DATA_PREFIX;
            drv_state[BS_LAST_BIT]   = (nxt_idx == cur_len);
            drv_state[BS_WRITE_BIT]  = cur_write;
            for (int k = 0; k < DATA_BYTES; k++) begin
               if (cur_write && (nxt_idx == 2'(k))) drv_data = cur_wdata[8*k +: 8];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_IDLE;
         idx               <= '0;
         mask_q            <= '0;
         bus_handshake_req <= 1'b0;
         memory_done       <= 1'b0;
         memory_rdata      <= '0;
         bus_output_enable <= 1'b0;
         bus_data_out      <= '0;
         bus_state         <= '0;
      end else begin
         state             <= nxt_state;
         idx               <= nxt_idx;
         bus_output_enable <= drv_oe;
         bus_data_out      <= drv_data;
         bus_state         <= drv_state;
         memory_done       <= complete;
         if (accept) mask_q <= cmp_mask;
         // req only rises once the peripheral has released ack from the previous phase.
         if (phase_done)
            bus_handshake_req <= 1'b0;
         else if (!bus_handshake_req && !bus_handshake_ack && (state != ST_IDLE))
            bus_handshake_req <= 1'b1;
         if (accept) begin
            for (int k = 0; k < DATA_BYTES; k++) begin
               if (2'(k) > memory_len) memory_rdata[8*k +: 8] <= '0;
            end
         end
         if (phase_done && (state == ST_DATA) && !write_q) begin
            for (int k = 0; k < DATA_BYTES; k++) begin
               if (idx == 2'(k)) memory_rdata[8*k +: 8] <= bus_data_in;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= memory_addr;
         wdata_q <= memory_wdata;
         len_q   <= memory_len;
         write_q <= memory_write;
         io_q    <= memory_io;
      end
   end

endmodule

// File: tb/tb_bus_if_burst.sv
// Directed bench for bus_if_burst with a configurable-latency req/ack peripheral model.
module tb_bus_if_burst;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bus_handshake_ack;
   logic        bus_handshake_req;
   logic [2:0]  bus_state;
   logic [7:0]  bus_data_in;
   logic [7:0]  bus_data_out;
   logic        bus_output_enable;
   logic        bus_io;
   logic        memory_read, memory_write;
   logic [15:0] memory_addr;
   logic        memory_io;
   logic [1:0]  memory_len;
   logic [31:0] memory_wdata;
   logic [31:0] memory_rdata;
   logic        memory_done;
   logic        shadow_invalidate;
   logic        inv_manual, inv_auto;

   int checks = 0;
   int errors = 0;

   int   ack_delay = 1, ack_hold = 1, cnt = 0, hcnt = 0;
   bit   inv_on_last = 0;
   logic req_last = 1'b0;
   logic [7:0] held_data;
   logic [2:0] held_state;
   int   rise_viol = 0, stab_viol = 0, done_cnt = 0;
   logic [2:0] log_st[$];
   logic [7:0] log_dat[$];
   logic       log_oe[$];
   logic [7:0] rd_q[$];

   assign shadow_invalidate = inv_manual | inv_auto;

   bus_if_burst #(.ADDR_BYTES(2), .DATA_BYTES(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .bus_handshake_ack (bus_handshake_ack),
      .bus_handshake_req (bus_handshake_req),
      .bus_state         (bus_state),
      .bus_data_in       (bus_data_in),
      .bus_data_out      (bus_data_out),
      .bus_output_enable (bus_output_enable),
      .bus_io            (bus_io),
      .memory_read       (memory_read),
      .memory_write      (memory_write),
      .memory_addr       (memory_addr),
      .memory_io         (memory_io),
      .memory_len        (memory_len),
      .memory_wdata      (memory_wdata),
      .memory_rdata      (memory_rdata),
      .memory_done       (memory_done),
      .shadow_invalidate (shadow_invalidate)
   );

   always #5 clk = ~clk;

   // Peripheral: raises ack ack_delay negedges after req, drops it ack_hold negedges after req falls.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus_handshake_ack = 1'b0; cnt = 0; hcnt = 0; req_last = 1'b0; inv_auto = 1'b0;
      end else begin
         if (memory_done) done_cnt++;
         if (bus_handshake_req && !req_last && bus_handshake_ack) rise_viol++;
         if (bus_handshake_req && req_last &&
             (bus_data_out !== held_data || bus_state !== held_state)) stab_viol++;
         if (bus_handshake_req && !req_last) begin
            held_data = bus_data_out; held_state = bus_state;
         end
         req_last = bus_handshake_req;
         inv_auto = 1'b0;
         if (bus_handshake_req && !bus_handshake_ack) begin
            if (cnt >= ack_delay) begin
               bus_handshake_ack = 1'b1; cnt = 0;
               log_st.push_back(bus_state); log_dat.push_back(bus_data_out);
               log_oe.push_back(bus_output_enable);
               if (bus_state[2] && !bus_state[0])
                  bus_data_in = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
               if (inv_on_last && bus_state[2] && bus_state[1]) inv_auto = 1'b1;
            end else cnt++;
         end else if (!bus_handshake_req && bus_handshake_ack) begin
            if (hcnt >= ack_hold) begin
               bus_handshake_ack = 1'b0; hcnt = 0;
            end else hcnt++;
         end
      end
   end

   task automatic do_req(input logic wr, input logic [15:0] a, input logic io,
                         input logic [1:0] len, input logic [31:0] wd,
                         output int cyc, output bit tmo);
      log_st.delete(); log_dat.delete(); log_oe.delete();
      @(negedge clk);
      memory_addr = a; memory_io = io; memory_len = len; memory_wdata = wd;
      memory_write = wr; memory_read = !wr;
      cyc = 0; tmo = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cyc++;
         if (memory_done) begin tmo = 1'b0; break; end
      end
      memory_read = 1'b0; memory_write = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus_handshake_ack = 1'b0; bus_data_in = 8'h00;
      memory_read = 1'b0; memory_write = 1'b0; memory_addr = '0; memory_io = 1'b0;
      memory_len = '0; memory_wdata = '0; inv_manual = 1'b0; inv_auto = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus_handshake_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus_handshake_req); end
      checks++; if (memory_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", memory_done); end
      checks++; if (memory_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", memory_rdata); end
      checks++; if ({bus_output_enable, bus_data_out, bus_state} !== 12'h000) begin
         errors++; $display("FAIL reset_bus: got oe=%b data=%h state=%b want all 0", bus_output_enable, bus_data_out, bus_state); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_read_basic();
      int cyc; bit tmo; int d0;
      logic [2:0] es [3]; logic [7:0] ed [3];
      es = '{3'b000, 3'b001, 3'b110}; ed = '{8'h34, 8'h12, 8'h00};
      d0 = done_cnt; rd_q.push_back(8'hA5);
      do_req(1'b0, 16'h1234, 1'b0, 2'd0, 32'h0, cyc, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL read_basic_timeout: no done within bound"); end
      checks++; if (log_st.size() != 3) begin errors++; $display("FAIL read_basic_phases: got %0d want 3", log_st.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i < log_st.size() && {log_st[i], log_dat[i]} !== {es[i], ed[i]}) begin
            errors++; $display("FAIL read_basic_phase%0d: got %b/%h want %b/%h", i, log_st[i], log_dat[i], es[i], ed[i]); end
      end
      checks++; if (log_oe.size() == 3 && {log_oe[0], log_oe[1], log_oe[2]} !== 3'b110) begin
         errors++; $display("FAIL read_basic_oe: got %b%b%b want 110", log_oe[0], log_oe[1], log_oe[2]); end
      checks++; if (memory_rdata !== 32'h000000A5) begin errors++; $display("FAIL read_basic_rdata: got %h want 000000a5", memory_rdata); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL read_basic_done_pulses: got %0d want 1", done_cnt - d0); end
      checks++; if (cyc != 12) begin errors++; $display("FAIL read_basic_latency: got %0d want 12", cyc); end
   endtask

   task automatic test_write_burst();
      int cyc; bit tmo;
      logic [2:0] es [6]; logic [7:0] ed [6];
      es = '{3'b000, 3'b001, 3'b101, 3'b101, 3'b101, 3'b111};
      ed = '{8'h00, 8'h20, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_req(1'b1, 16'h2000, 1'b0, 2'd3, 32'hDDCCBBAA, cyc, tmo);
      checks++; if (log_st.size() != 6) begin errors++; $display("FAIL write_phases: got %0d want 6", log_st.size()); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i < log_st.size() && {log_oe[i], log_st[i], log_dat[i]} !== {1'b1, es[i], ed[i]}) begin
            errors++; $display("FAIL write_phase%0d: got oe=%b %b/%h want 1 %b/%h", i, log_oe[i], log_st[i], log_dat[i], es[i], ed[i]); end
      end
      checks++; if (tmo || cyc != 24) begin errors++; $display("FAIL write_latency: got %0d want 24", cyc); end
      rd_q.push_back(8'h5A);
      do_req(1'b0, 16'h2004, 1'b0, 2'd0, 32'h0, cyc, tmo);
      checks++; if (log_st.size() != 1 || log_st[0] !== 3'b110) begin
         errors++; $display("FAIL follow_read_no_addr: got %0d phases first %b want 1 phase 110", log_st.size(), log_st[0]); end
      checks++; if (memory_rdata !== 32'h0000005A) begin errors++; $display("FAIL follow_read_rdata: got %h want 0000005a", memory_rdata); end
   endtask

   task automatic test_shadow_partial();
      int cyc; bit tmo;
      // shadow 0x2005: 0x20FF needs only the low byte
      rd_q.push_back(8'h11); rd_q.push_back(8'h22);
      do_req(1'b0, 16'h20FF, 1'b0, 2'd1, 32'h0, cyc, tmo);
      checks++; if (log_st.size() != 3 || {log_st[0], log_dat[0], log_st[1], log_st[2]} !== {3'b000, 8'hFF, 3'b100, 3'b110}) begin
         errors++; $display("FAIL partial_low_byte: got %0d phases first %b/%h want 3 phases 000/ff", log_st.size(), log_st[0], log_dat[0]); end
      checks++; if (memory_rdata !== 32'h00002211) begin errors++; $display("FAIL partial_rdata2: got %h want 00002211", memory_rdata); end
      // shadow carried into 0x2101
      rd_q.push_back(8'h33);
      do_req(1'b0, 16'h2101, 1'b0, 2'd0, 32'h0, cyc, tmo);
      checks++; if (log_st.size() != 1) begin errors++; $display("FAIL carry_no_addr: got %0d phases want 1", log_st.size()); end
      checks++; if (memory_rdata !== 32'h00000033) begin errors++; $display("FAIL rdata_clear: got %h want 00000033", memory_rdata); end
      do_req(1'b0, 16'h2103, 1'b0, 2'd0, 32'h0, cyc, tmo);
      checks++; if (log_st.size() != 2 || {log_st[0], log_dat[0]} !== {3'b000, 8'h03}) begin
         errors++; $display("FAIL only_byte0: got %0d phases first %b/%h want 2 phases 000/03", log_st.size(), log_st[0], log_dat[0]); end
      do_req(1'b0, 16'h2204, 1'b0, 2'd0, 32'h0, cyc, tmo);
      checks++; if (log_st.size() != 2 || {log_st[0], log_dat[0]} !== {3'b001, 8'h22}) begin
         errors++; $display("FAIL only_byte1: got %0d phases first %b/%h want 2 phases 001/22", log_st.size(), log_st[0], log_dat[0]); end
   endtask

   task automatic test_slow_peripheral();
      int cyc; bit tmo;
      logic [2:0] es [4]; logic [7:0] ed [4];
      es = '{3'b000, 3'b001, 3'b101, 3'b111}; ed = '{8'h00, 8'h30, 8'h66, 8'h55};
      ack_delay = 5; ack_hold = 3; rise_viol = 0; stab_viol = 0;
      do_req(1'b1, 16'h3000, 1'b0, 2'd1, 32'h00005566, cyc, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL slow_timeout: no done within bound"); end
      checks++; if (rise_viol != 0) begin errors++; $display("FAIL slow_req_rise_under_ack: got %0d want 0", rise_viol); end
      checks++; if (stab_viol != 0) begin errors++; $display("FAIL slow_bus_stability: got %0d want 0", stab_viol); end
      checks++; if (log_st.size() != 4) begin errors++; $display("FAIL slow_phases: got %0d want 4", log_st.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i < log_st.size() && {log_st[i], log_dat[i]} !== {es[i], ed[i]}) begin
            errors++; $display("FAIL slow_phase%0d: got %b/%h want %b/%h", i, log_st[i], log_dat[i], es[i], ed[i]); end
      end
      ack_delay = 1; ack_hold = 1;
   endtask

   task automatic test_invalidate();
      int cyc; bit tmo;
      do_req(1'b0, 16'h3002, 1'b1, 2'd0, 32'h0, cyc, tmo);
      checks++; if (log_st.size() != 3) begin errors++; $display("FAIL io_toggle_resend: got %0d phases want 3", log_st.size()); end
      @(negedge clk); inv_manual = 1'b1; @(negedge clk); inv_manual = 1'b0;
      do_req(1'b0, 16'h3003, 1'b1, 2'd0, 32'h0, cyc, tmo);
      checks++; if (log_st.size() != 3) begin errors++; $display("FAIL idle_invalidate_resend: got %0d phases want 3", log_st.size()); end
      inv_on_last = 1'b1;
      do_req(1'b0, 16'h3004, 1'b1, 2'd0, 32'h0, cyc, tmo);
      inv_on_last = 1'b0;
      checks++; if (log_st.size() != 1) begin errors++; $display("FAIL shadow_hit_before_inv: got %0d phases want 1", log_st.size()); end
      rd_q.push_back(8'h77);
      do_req(1'b0, 16'h3005, 1'b1, 2'd0, 32'h0, cyc, tmo);
      checks++; if (log_st.size() != 3) begin errors++; $display("FAIL coincident_invalidate_resend: got %0d phases want 3", log_st.size()); end
   endtask

   task automatic test_reset_mid_transfer();
      int cyc; bit tmo; int d0; bit found;
      log_st.delete(); log_dat.delete(); log_oe.delete();
      @(negedge clk);
      memory_addr = 16'h4000; memory_io = 1'b0; memory_len = 2'd2; memory_wdata = 32'h00B2B1B0;
      memory_write = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus_handshake_req && bus_state == 3'b101 && bus_data_out == 8'hB1) begin found = 1'b1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL rst_reach_data1: data byte 1 not reached within bound"); end
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({bus_handshake_req, bus_output_enable, bus_state, bus_data_out} !== 13'h0) begin
         errors++; $display("FAIL rst_async_outputs: got req=%b oe=%b state=%b data=%h want all 0",
                            bus_handshake_req, bus_output_enable, bus_state, bus_data_out); end
      checks++; if (memory_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", memory_rdata); end
      memory_write = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - d0); end
      do_req(1'b0, 16'h3006, 1'b1, 2'd0, 32'h0, cyc, tmo);
      checks++; if (log_st.size() != 3 || {log_dat[0], log_dat[1]} !== 16'h0630) begin
         errors++; $display("FAIL rst_full_addr: got %0d phases bytes %h %h want 3 phases 06 30", log_st.size(), log_dat[0], log_dat[1]); end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_write_burst();
      test_shadow_partial();
      test_slow_peripheral();
      test_invalidate();
      test_reset_mid_transfer();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
